// File: rtl/gshare_bpu_if.sv
// Fetch/execute-side bundle of the branch prediction unit: lookup PC, resolution
// feedback and the registered prediction.
interface gshare_bpu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_i;
  logic            res_valid_i;
  logic [XLEN-1:0] res_pc_i;
  logic [XLEN-1:0] res_target_i;
  logic            res_taken_i;
  logic            res_mispredict_i;
  logic            pred_valid_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            pred_hit_o;

  modport master (
    output pc_i, res_valid_i, res_pc_i, res_target_i, res_taken_i, res_mispredict_i,
    input  pred_valid_o, pred_taken_o, pred_target_o, pred_hit_o
  );

  modport slave (
    input  pc_i, res_valid_i, res_pc_i, res_target_i, res_taken_i, res_mispredict_i,
    output pred_valid_o, pred_taken_o, pred_target_o, pred_hit_o
  );
endinterface

// File: rtl/gshare_bpu.sv
// Gshare branch predictor: direct-mapped BTB plus a PHT of saturating counters
// indexed by PC XOR global history (bimodal when HIST_LEN=0).
module gshare_bpu #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int CNT_W       = 2,
  parameter int HIST_LEN    = 8,
  localparam int GHR_W      = (HIST_LEN > 0) ? HIST_LEN : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  gshare_bpu_if.slave      bus,
  output logic [GHR_W-1:0] ghr_o,
  output logic [31:0]      mispred_cnt_o
);

  localparam int BI_W  = $clog2(BTB_ENTRIES);
  localparam int PI_W  = $clog2(PHT_ENTRIES);
  localparam int TAG_W = XLEN - BI_W - 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);

  logic             btb_valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_tgt_q   [BTB_ENTRIES];
  logic [CNT_W-1:0] pht_q       [PHT_ENTRIES];

  logic [GHR_W-1:0] ghr_q;
  logic [31:0]      cnt_q, cnt_d;

  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic             pred_hit_q, pred_hit_d;
  logic [XLEN-1:0]  pred_target_q, pred_target_d;

  logic [PI_W-1:0]  ghr_ext;
  logic [BI_W-1:0]  lk_bi, rs_bi;
  logic [PI_W-1:0]  lk_pi, rs_pi;
  logic [TAG_W-1:0] lk_tag, rs_tag;
  logic             lk_hit, lk_taken;
  logic [CNT_W-1:0] rs_cnt, rs_cnt_d;

  logic unused_ok;
  assign unused_ok = ^{bus.pc_i[1:0], bus.res_pc_i[1:0]};

  always_comb begin
    ghr_ext                = '0;
    ghr_ext[GHR_W-1:0]     = ghr_q;
    lk_bi                  = bus.pc_i[BI_W+1:2];
    lk_tag                 = bus.pc_i[XLEN-1:BI_W+2];
    lk_pi                  = bus.pc_i[PI_W+1:2] ^ ghr_ext;
    rs_bi                  = bus.res_pc_i[BI_W+1:2];
    rs_tag                 = bus.res_pc_i[XLEN-1:BI_W+2];
    rs_pi                  = bus.res_pc_i[PI_W+1:2] ^ ghr_ext;
  end

  // Lookup reads the tables as registered, so a same-cycle update is not bypassed.
  always_comb begin
    lk_hit        = btb_valid_q[lk_bi] && (btb_tag_q[lk_bi] == lk_tag);
    lk_taken      = lk_hit && pht_q[lk_pi][CNT_W-1];
    pred_valid_d  = !flush_i;
    pred_hit_d    = lk_hit;
    pred_taken_d  = lk_taken && !flush_i;
    pred_target_d = pred_taken_d ? btb_tgt_q[lk_bi] : bus.pc_i + PC_STEP;
  end

  always_comb begin
    rs_cnt   = pht_q[rs_pi];
    rs_cnt_d = rs_cnt;
    if (bus.res_taken_i) begin
      if (rs_cnt != '1) rs_cnt_d = rs_cnt + CNT_W'(1);
    end else begin
      if (rs_cnt != '0) rs_cnt_d = rs_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.res_valid_i && bus.res_mispredict_i && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[BI_W'(i)] <= 1'b0;
        btb_tag_q[BI_W'(i)]   <= '0;
        btb_tgt_q[BI_W'(i)]   <= '0;
      end
      for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[PI_W'(i)] <= CNT_INIT;
      end
    end else if (bus.res_valid_i) begin
      pht_q[rs_pi] <= rs_cnt_d;
      if (bus.res_taken_i) begin
        btb_valid_q[rs_bi] <= 1'b1;
        btb_tag_q[rs_bi]   <= rs_tag;
        btb_tgt_q[rs_bi]   <= bus.res_target_i;
      end
    end
  end

  if (HIST_LEN > 0) begin : g_ghr
    logic [GHR_W-1:0] ghr_d;
    always_comb begin
      ghr_d = ghr_q;
      if (bus.res_valid_i) ghr_d = (ghr_q << 1) | GHR_W'(bus.res_taken_i);
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) ghr_q <= '0;
      else          ghr_q <= ghr_d;
    end
  end else begin : g_no_ghr
    assign ghr_q = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_target_q <= '0;
      cnt_q         <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_hit_q    <= pred_hit_d;
      pred_target_q <= pred_target_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.pred_valid_o  = pred_valid_q;
  assign bus.pred_taken_o  = pred_taken_q;
  assign bus.pred_hit_o    = pred_hit_q;
  assign bus.pred_target_o = pred_target_q;
  assign ghr_o             = ghr_q;
  assign mispred_cnt_o     = cnt_q;

endmodule

// File: tb/tb_gshare_bpu.sv
// Bench for gshare_bpu: a bimodal and an 8-bit-history instance driven in lockstep
// and compared every cycle against an index/array reference model.
module tb_gshare_bpu;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            flush_i;
  logic [XLEN-1:0] pc, rpc, rtgt;
  logic            rv, rt, rm;
  logic [0:0]      ghr0;
  logic [7:0]      ghr8;
  logic [31:0]     cnt0, cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  gshare_bpu_if #(.XLEN(XLEN)) bif0 ();
  gshare_bpu_if #(.XLEN(XLEN)) bif8 ();

  assign bif0.pc_i = pc;             assign bif8.pc_i = pc;
  assign bif0.res_valid_i = rv;      assign bif8.res_valid_i = rv;
  assign bif0.res_pc_i = rpc;        assign bif8.res_pc_i = rpc;
  assign bif0.res_target_i = rtgt;   assign bif8.res_target_i = rtgt;
  assign bif0.res_taken_i = rt;      assign bif8.res_taken_i = rt;
  assign bif0.res_mispredict_i = rm; assign bif8.res_mispredict_i = rm;

  gshare_bpu #(.XLEN(XLEN), .BTB_ENTRIES(64), .PHT_ENTRIES(256), .CNT_W(2), .HIST_LEN(0)) dut0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .bus(bif0.slave),
    .ghr_o(ghr0), .mispred_cnt_o(cnt0));

  gshare_bpu #(.XLEN(XLEN), .BTB_ENTRIES(64), .PHT_ENTRIES(256), .CNT_W(2), .HIST_LEN(8)) dut8 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .bus(bif8.slave),
    .ghr_o(ghr8), .mispred_cnt_o(cnt8));

  // Reference model, index 0 = bimodal, index 1 = 8-bit history.
  int unsigned pht  [2][256];
  bit          bv   [2][64];
  int unsigned btag [2][64];
  logic [31:0] btgt [2][64];
  int unsigned ghr  [2];
  int unsigned mcnt [2];
  bit          ev [2], et [2], eh [2];
  logic [31:0] etg [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) pht[k][i] = 1;
      for (int i = 0; i < 64; i++) begin
        bv[k][i] = 0; btag[k][i] = 0; btgt[k][i] = '0;
      end
      ghr[k] = 0; mcnt[k] = 0;
      ev[k] = 0; et[k] = 0; eh[k] = 0; etg[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int unsigned p, bi, pi, hmask;
      hmask = (k == 0) ? 0 : 255;
      p  = pc;
      bi = (p / 4) % 64;
      pi = ((p / 4) % 256) ^ ghr[k];
      eh[k]  = bv[k][bi] && (btag[k][bi] == p / 256);
      ev[k]  = !flush_i;
      et[k]  = !flush_i && eh[k] && (pht[k][pi] >= 2);
      etg[k] = et[k] ? btgt[k][bi] : pc + 32'd4;
      if (rv) begin
        p  = rpc;
        bi = (p / 4) % 64;
        pi = ((p / 4) % 256) ^ ghr[k];
        if (rt && pht[k][pi] < 3) pht[k][pi]++;
        if (!rt && pht[k][pi] > 0) pht[k][pi]--;
        if (rt) begin
          bv[k][bi] = 1; btag[k][bi] = p / 256; btgt[k][bi] = rtgt;
        end
        ghr[k] = ((ghr[k] * 2) + (rt ? 1 : 0)) & hmask;
        if (rm && mcnt[k] != 32'hFFFF_FFFF) mcnt[k]++;
      end
    end
  endtask

  task automatic compare_all();
    check("b.valid",  bif0.pred_valid_o,  ev[0]);
    check("b.hit",    bif0.pred_hit_o,    eh[0]);
    check("b.taken",  bif0.pred_taken_o,  et[0]);
    check("b.target", bif0.pred_target_o, etg[0]);
    check("b.ghr",    ghr0,               ghr[0]);
    check("b.cnt",    cnt0,               mcnt[0]);
    check("g.valid",  bif8.pred_valid_o,  ev[1]);
    check("g.hit",    bif8.pred_hit_o,    eh[1]);
    check("g.taken",  bif8.pred_taken_o,  et[1]);
    check("g.target", bif8.pred_target_o, etg[1]);
    check("g.ghr",    ghr8,               ghr[1]);
    check("g.cnt",    cnt8,               mcnt[1]);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic [31:0] p, input bit v, input logic [31:0] rp,
                        input logic [31:0] tg, input bit tk, input bit m, input bit fl);
    pc = p; rv = v; rpc = rp; rtgt = tg; rt = tk; rm = m; flush_i = fl;
  endtask

  // Asserts reset between edges, checks the async clear, releases on a falling edge.
  task automatic do_reset();
    #3;
    rst_n_i = 1'b0;
    model_reset();
    #1;
    compare_all();
    set_in(32'd40, 0, '0, '0, 0, 0, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
  endfunction

  initial begin
    rst_n_i = 1'b0;
    set_in(32'd40, 0, '0, '0, 0, 0, 0);
    model_reset();
    #12;
    compare_all();
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Cold lookup after reset.
    cycle();
    check("t1.hit", bif0.pred_hit_o, 0);
    check("t1.taken", bif0.pred_taken_o, 0);
    check("t1.target", bif0.pred_target_o, 44);
    check("t1.valid", bif0.pred_valid_o, 1);

    // Two taken resolutions of 40 -> 8.
    set_in(32'h1000, 1, 32'd40, 32'd8, 1, 0, 0); cycle(); cycle();
    set_in(32'd40, 0, '0, '0, 0, 0, 0); cycle();
    check("t2.hit", bif0.pred_hit_o, 1);
    check("t2.taken", bif0.pred_taken_o, 1);
    check("t2.target", bif0.pred_target_o, 8);

    // Saturation then decay.
    set_in(32'h1000, 1, 32'd40, 32'd8, 1, 0, 0); repeat (3) cycle();
    set_in(32'h1000, 1, 32'd40, 32'd8, 0, 0, 0); cycle();
    set_in(32'd40, 0, '0, '0, 0, 0, 0); cycle();
    check("t3.taken10", bif0.pred_taken_o, 1);
    set_in(32'h1000, 1, 32'd40, 32'd8, 0, 0, 0); cycle();
    set_in(32'd40, 0, '0, '0, 0, 0, 0); cycle();
    check("t3.taken01", bif0.pred_taken_o, 0);
    check("t3.target", bif0.pred_target_o, 44);
    check("t3.hit", bif0.pred_hit_o, 1);

    // Same-cycle lookup and first training of a fresh entry.
    set_in(32'h84, 1, 32'h84, 32'h10, 1, 0, 0); cycle();
    check("t4.hit_same", bif0.pred_hit_o, 0);
    set_in(32'h84, 0, '0, '0, 0, 0, 0); cycle();
    check("t4.hit_next", bif0.pred_hit_o, 1);

    // BTB alias: 296 shares the slot of 40.
    set_in(32'h1000, 1, 32'd296, 32'd100, 1, 0, 0); cycle();
    set_in(32'd40, 0, '0, '0, 0, 0, 0); cycle();
    check("t5.alias_hit", bif0.pred_hit_o, 0);
    set_in(32'd296, 0, '0, '0, 0, 0, 0); cycle();
    check("t5.target", bif0.pred_target_o, 100);

    // Fall-through wraps.
    set_in(32'hFFFF_FFFC, 0, '0, '0, 0, 0, 0); cycle();
    check("wrap.target", bif0.pred_target_o, 0);

    // History, flush and mispredict counter with async clear.
    do_reset();
    set_in(32'h1000, 1, 32'd40, 32'd8, 1, 0, 0); cycle();
    set_in(32'h1000, 1, 32'd40, 32'd8, 0, 0, 0); cycle();
    set_in(32'h1000, 1, 32'd40, 32'd8, 1, 0, 0); cycle();
    set_in(32'd40, 0, '0, '0, 0, 0, 1); cycle();
    check("t6.ghr", ghr8, 8'b101);
    check("t6.flush_valid", bif8.pred_valid_o, 0);
    check("t6.flush_taken", bif8.pred_taken_o, 0);
    check("t6.flush_target", bif8.pred_target_o, 44);
    set_in(32'h1000, 1, 32'h2000, 32'h30, 1, 1, 0); repeat (5) cycle();
    check("t6.cnt5", cnt8, 5);
    do_reset();
    check("t6.cnt_rst", cnt8, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in(rand_pc(), ($urandom_range(0, 1) == 1), rand_pc(), $urandom,
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) == 0));
      cycle();
      if (n == 1500) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
